// File: rtl/output_seq_pkg.sv
// Shared constants, state encoding and nibble-packing helper for the
// read-mode output sequencer.
package output_seq_pkg;

  localparam int NUM_ADC      = 128;
  localparam int ADC_IDX_W    = 7;
  localparam int NIB_PER_WORD = 8;
  localparam int ENC_W        = 4;
  localparam int SUM_W        = 11;
  localparam int WORD_W       = 32;
  localparam int CNT_W        = 8;
  localparam int NIB_W        = 3;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LATCH = 3'd1,
    READ  = 3'd2,
    STALL = 3'd3,
    DONE  = 3'd4
  } state_e;

  // Replace nibble slot 'slot' of 'word' with 'nib'; slot 0 is bits [3:0].
  function automatic logic [WORD_W-1:0] put_nibble(input logic [WORD_W-1:0] word,
                                                   input logic [NIB_W-1:0]  slot,
                                                   input logic [ENC_W-1:0]  nib);
    logic [WORD_W-1:0] w_res;
    w_res = word;
    w_res[{slot, 2'b00} +: ENC_W] = nib;
    return w_res;
  endfunction

endpackage

// File: rtl/output_seq_fifo.sv
// Synchronous first-word-fall-through FIFO for packed result words.
// Push while full is accepted only when a pop happens in the same cycle.
// The head output reads as zero while empty.
module output_seq_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             i_clear,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic             o_full,
  output logic             o_empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_do_pop;
  logic             w_do_push;

  assign o_empty   = (r_count == '0);
  assign o_full    = (r_count == (AW+1)'(DEPTH));
  assign w_do_pop  = i_pop & ~o_empty;
  assign w_do_push = i_push & (~o_full | w_do_pop);
  assign o_data    = o_empty ? '0 : r_mem[r_rd_ptr];

  // Storage array; contents are don't-care until written, so no reset.
  always_ff @(posedge clk_i) begin
    if (w_do_push && !i_clear) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  // Pointers and occupancy; clear empties the FIFO in one cycle.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_clear) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/output_read_sequencer.sv
// Read-mode output buffer sequencer: sweeps ADC columns, strobes buffer
// latch then read per column, packs eight 4b results per 32b word and
// queues words for the CPU side.
// Optional feature: define OUTPUT_SEQ_SUM_EN to add sum_o/sum_valid_o
// (running sum of encoder results over the sweep).
//
// state | meaning
// IDLE  | waiting for start_i
// LATCH | buf_w_en_o high, buffer captures column idx
// READ  | buf_r_en_o high, encoder nibble packed; word pushed if complete
// STALL | completed word waiting for FIFO space
// DONE  | one-cycle done_o after last word pushed
module output_read_sequencer
  import output_seq_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 start_i,
  input  logic                 clear_i,
  input  logic [ADC_IDX_W-1:0] col_start_i,
  input  logic [CNT_W-1:0]     num_adc_i,
  output logic                 buf_w_en_o,
  output logic                 buf_r_en_o,
  output logic [8:0]           col_addr9_o,
  input  logic [WORD_W-1:0]    enc_i,
  output logic                 word_valid_o,
  output logic [WORD_W-1:0]    word_o,
  input  logic                 word_ready_i,
  output logic                 busy_o,
  output logic                 done_o
`ifdef OUTPUT_SEQ_SUM_EN
  ,
  output logic [SUM_W-1:0]     sum_o,
  output logic                 sum_valid_o
`endif
);

  localparam logic [2:0] ST_IDLE  = IDLE;
  localparam logic [2:0] ST_LATCH = LATCH;
  localparam logic [2:0] ST_READ  = READ;
  localparam logic [2:0] ST_STALL = STALL;
  localparam logic [2:0] ST_DONE  = DONE;

  logic [2:0]           r_state;
  logic [2:0]           w_state_nxt;
  logic [ADC_IDX_W-1:0] r_idx;
  logic [CNT_W-1:0]     r_remain;
  logic [NIB_W-1:0]     r_nib;
  logic [WORD_W-1:0]    r_pack;

  logic [WORD_W-1:0]    w_pack_upd;
  logic [ENC_W-1:0]     w_enc;
  logic                 w_enc_unused;
  logic                 w_start_ok;
  logic                 w_last;
  logic                 w_word_done;
  logic                 w_pop;
  logic                 w_space;
  logic                 w_push;
  logic [WORD_W-1:0]    w_push_data;
  logic                 w_fifo_full;
  logic                 w_fifo_empty;
  logic [WORD_W-1:0]    w_fifo_data;

  // Only the low ENC_W bits of the buffer output carry the encoded value.
  assign w_enc        = enc_i[ENC_W-1:0];
  assign w_enc_unused = ^enc_i[WORD_W-1:ENC_W];

  assign w_start_ok  = start_i & (r_state == ST_IDLE);
  assign w_last      = (r_remain == CNT_W'(1));
  assign w_word_done = (r_nib == NIB_W'(NIB_PER_WORD - 1)) | w_last;
  assign w_pack_upd  = put_nibble(r_pack, r_nib, w_enc);

  // A pop in the same cycle frees a slot before our push lands.
  assign w_pop   = word_valid_o & word_ready_i;
  assign w_space = ~w_fifo_full | w_pop;

  // Push decision: completed word from READ, or the held word from STALL.
  always_comb begin
    w_push      = 1'b0;
    w_push_data = r_pack;
    if (!clear_i) begin
      if (r_state == ST_READ) begin
        w_push      = w_word_done & w_space;
        w_push_data = w_pack_upd;
      end else if (r_state == ST_STALL) begin
        w_push      = w_space;
        w_push_data = r_pack;
      end
    end
  end

  // Next-state logic; clear_i overrides everything.
  always_comb begin
    w_state_nxt = r_state;
    if (clear_i) begin
      w_state_nxt = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start_i) begin
            w_state_nxt = (num_adc_i == '0) ? ST_DONE : ST_LATCH;
          end
        end
        ST_LATCH: w_state_nxt = ST_READ;
        ST_READ: begin
          if (w_word_done && !w_space) w_state_nxt = ST_STALL;
          else if (w_last)             w_state_nxt = ST_DONE;
          else                         w_state_nxt = ST_LATCH;
        end
        ST_STALL: begin
          if (w_space) begin
            w_state_nxt = (r_remain == '0) ? ST_DONE : ST_LATCH;
          end
        end
        ST_DONE:  w_state_nxt = ST_IDLE;
        default:  w_state_nxt = ST_IDLE;
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_state <= ST_IDLE;
    else         r_state <= w_state_nxt;
  end

  // Column index, remaining-ADC down-counter, nibble slot and pack register.
  // The counters advance at the end of READ, so in STALL r_remain==0 marks
  // the held word as the final one.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_idx    <= '0;
      r_remain <= '0;
      r_nib    <= '0;
      r_pack   <= '0;
    end else if (clear_i) begin
      r_idx    <= '0;
      r_remain <= '0;
      r_nib    <= '0;
      r_pack   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_start_ok) begin
            r_idx    <= col_start_i;
            r_remain <= num_adc_i;
            r_nib    <= '0;
            r_pack   <= '0;
          end
        end
        ST_READ: begin
          r_idx    <= r_idx + ADC_IDX_W'(1);
          r_remain <= r_remain - CNT_W'(1);
          if (w_word_done) begin
            r_nib  <= '0;
            r_pack <= w_space ? '0 : w_pack_upd;
          end else begin
            r_nib  <= r_nib + NIB_W'(1);
            r_pack <= w_pack_upd;
          end
        end
        ST_STALL: begin
          if (w_space) r_pack <= '0;
        end
        default: ;
      endcase
    end
  end

  output_seq_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (WORD_W)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .i_clear (clear_i),
    .i_push  (w_push),
    .i_data  (w_push_data),
    .i_pop   (w_pop),
    .o_data  (w_fifo_data),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty)
  );

  assign word_valid_o = ~w_fifo_empty;
  assign word_o       = w_fifo_data;

  assign buf_w_en_o  = (r_state == ST_LATCH);
  assign buf_r_en_o  = (r_state == ST_READ);
  assign col_addr9_o = (buf_w_en_o | buf_r_en_o) ? {r_idx, 2'b00} : 9'd0;
  assign busy_o      = (r_state != ST_IDLE);
  assign done_o      = (r_state == ST_DONE);

`ifdef OUTPUT_SEQ_SUM_EN
  logic [SUM_W-1:0] r_sum;
  logic             r_sum_valid;

  // Running encoder sum; valid flag held from DONE until the next start.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_sum       <= '0;
      r_sum_valid <= 1'b0;
    end else if (clear_i) begin
      r_sum       <= '0;
      r_sum_valid <= 1'b0;
    end else if (w_start_ok) begin
      r_sum       <= '0;
      r_sum_valid <= 1'b0;
    end else begin
      if (r_state == ST_READ) r_sum <= r_sum + SUM_W'(w_enc);
      if (r_state == ST_DONE) r_sum_valid <= 1'b1;
    end
  end

  assign sum_o       = r_sum;
  assign sum_valid_o = r_sum_valid | done_o;
`endif

endmodule

// File: tb/tb_output_read_sequencer.sv
// Directed bench for output_read_sequencer with a behavioural output-buffer
// model and an expected-word queue computed from the column table.
module tb_output_read_sequencer;

  logic        clk_i;
  logic        rst_ni;
  logic        start_i;
  logic        clear_i;
  logic [6:0]  col_start_i;
  logic [7:0]  num_adc_i;
  logic        buf_w_en_o;
  logic        buf_r_en_o;
  logic [8:0]  col_addr9_o;
  logic [31:0] enc_i;
  logic        word_valid_o;
  logic [31:0] word_o;
  logic        word_ready_i;
  logic        busy_o;
  logic        done_o;
`ifdef OUTPUT_SEQ_SUM_EN
  logic [10:0] sum_o;
  logic        sum_valid_o;
`endif

  output_read_sequencer dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .start_i      (start_i),
    .clear_i      (clear_i),
    .col_start_i  (col_start_i),
    .num_adc_i    (num_adc_i),
    .buf_w_en_o   (buf_w_en_o),
    .buf_r_en_o   (buf_r_en_o),
    .col_addr9_o  (col_addr9_o),
    .enc_i        (enc_i),
    .word_valid_o (word_valid_o),
    .word_o       (word_o),
    .word_ready_i (word_ready_i),
    .busy_o       (busy_o),
    .done_o       (done_o)
`ifdef OUTPUT_SEQ_SUM_EN
    ,
    .sum_o        (sum_o),
    .sum_valid_o  (sum_valid_o)
`endif
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // Output buffer model: latch the column's value on buf_w_en, upper bits junk.
  logic [3:0] tbl [128];
  logic [3:0] buf_q = 4'h0;
  always @(posedge clk_i) if (buf_w_en_o) buf_q <= tbl[col_addr9_o[8:2]];
  assign enc_i = {28'hA5C3E71, buf_q};

  int n_chk = 0;
  int n_pass = 0;
  int n_popped = 0;
  logic [31:0] exp_q[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  // Expected words: nibble k of the sweep comes from column (col+k) mod 128.
  task automatic model_sweep(input int col, input int num);
    logic [31:0] w;
    w = '0;
    for (int k = 0; k < num; k++) begin
      w[4*(k%8) +: 4] = tbl[(col + k) % 128];
      if ((k % 8) == 7 || k == num - 1) begin
        exp_q.push_back(w);
        w = '0;
      end
    end
  endtask

  task automatic start_sweep(input int col, input int num);
    col_start_i = 7'(col);
    num_adc_i   = 8'(num);
    model_sweep(col, num);
    start_i = 1'b1;
    step();
    start_i = 1'b0;
  endtask

  task automatic wait_done(input int max, input bit rnd_ready, input string nm);
    int c;
    c = 0;
    while (!done_o && c < max) begin
      if (rnd_ready) word_ready_i = 1'($urandom_range(0, 1));
      step();
      c++;
    end
    chk(nm, {31'b0, done_o}, 32'd1);
  endtask

  task automatic drain(input string nm);
    int c;
    word_ready_i = 1'b1;
    c = 0;
    while (word_valid_o && c < 40) begin
      step();
      c++;
    end
    chk({nm, "_drained"}, {31'b0, word_valid_o}, 32'd0);
    chk({nm, "_model_empty"}, exp_q.size(), 32'd0);
  endtask

  // Every cycle: enables exclusive; every pop must match the model head.
  always @(negedge clk_i) begin
    if (rst_ni) begin
      chk("buf_en_excl", {31'b0, buf_w_en_o & buf_r_en_o}, 32'd0);
      if (word_valid_o && word_ready_i) begin
        chk("pop_model_nonempty", {31'b0, exp_q.size() != 0}, 32'd1);
        if (exp_q.size() != 0) begin
          chk("word_head", word_o, exp_q.pop_front());
          n_popped++;
        end
      end
    end
  end

  int exp_addr [6] = '{496, 500, 504, 508, 0, 4};
  int addr_q[$];
  int base;
  int seen;

  initial begin
    rst_ni = 1'b0; start_i = 1'b0; clear_i = 1'b0;
    col_start_i = '0; num_adc_i = '0; word_ready_i = 1'b1;
    for (int i = 0; i < 128; i++) tbl[i] = 4'(i);
    step(); step();
    chk("rst_busy", {31'b0, busy_o}, 0);
    chk("rst_done", {31'b0, done_o}, 0);
    chk("rst_wen", {31'b0, buf_w_en_o}, 0);
    chk("rst_ren", {31'b0, buf_r_en_o}, 0);
    chk("rst_addr", {23'b0, col_addr9_o}, 0);
    chk("rst_valid", {31'b0, word_valid_o}, 0);
    chk("rst_word", word_o, 0);
    rst_ni = 1'b1;
    step();

    // T1: col 0, 8 ADCs, enc 0..7 -> 0x76543210, done 17 cycles after start.
    start_sweep(0, 8);
    chk("t1_model_pin", exp_q[0], 32'h76543210);
    for (int c = 1; c <= 17; c++) begin
      chk($sformatf("t1_busy_c%0d", c), {31'b0, busy_o}, 1);
      chk($sformatf("t1_done_c%0d", c), {31'b0, done_o}, {31'b0, c == 17});
      if (c < 17) step();
    end
    chk("t1_valid", {31'b0, word_valid_o}, 1);
    chk("t1_word", word_o, 32'h76543210);
    step();
    chk("t1_idle_busy", {31'b0, busy_o}, 0);
    chk("t1_idle_done", {31'b0, done_o}, 0);
    drain("t1");

    // T2: wrap 124..1, partial word.
    tbl[124] = 4'hA; tbl[125] = 4'hB; tbl[126] = 4'hC; tbl[127] = 4'hD;
    tbl[0] = 4'h1; tbl[1] = 4'h2;
    word_ready_i = 1'b0;
    start_sweep(124, 6);
    chk("t2_model_pin", exp_q[0], 32'h0021DCBA);
    for (int c = 1; c <= 12; c++) begin
      if (buf_w_en_o) addr_q.push_back(int'(col_addr9_o));
      step();
    end
    chk("t2_addr_count", addr_q.size(), 6);
    for (int i = 0; i < 6; i++)
      if (i < addr_q.size()) chk($sformatf("t2_addr%0d", i), addr_q[i], exp_addr[i]);
    chk("t2_done", {31'b0, done_o}, 1);
    chk("t2_word", word_o, 32'h0021DCBA);
    drain("t2");

    // T3: full sweep with consumer stalled, then release.
    for (int i = 0; i < 128; i++) tbl[i] = 4'((i * 7 + 3) % 16);
    base = n_popped;
    word_ready_i = 1'b0;
    start_sweep(0, 128);
    for (int c = 0; c < 100; c++) step();
    for (int c = 0; c < 3; c++) begin
      chk("t3_stall_busy", {31'b0, busy_o}, 1);
      chk("t3_stall_wen", {31'b0, buf_w_en_o}, 0);
      chk("t3_stall_ren", {31'b0, buf_r_en_o}, 0);
      chk("t3_stall_valid", {31'b0, word_valid_o}, 1);
      step();
    end
    word_ready_i = 1'b1;
    step();
    word_ready_i = 1'b0;
    chk("t3_resume_latch", {31'b0, buf_w_en_o}, 1);
    wait_done(3000, 1'b1, "t3_done");
    drain("t3");
    chk("t3_word_count", n_popped - base, 16);

    // T4: zero-length sweep, then start ignored while busy.
    start_sweep(5, 0);
    chk("t4_zero_done", {31'b0, done_o}, 1);
    chk("t4_zero_valid", {31'b0, word_valid_o}, 0);
    step();
    chk("t4_zero_done_off", {31'b0, done_o}, 0);
    chk("t4_zero_busy_off", {31'b0, busy_o}, 0);
    chk("t4_zero_valid2", {31'b0, word_valid_o}, 0);
    base = n_popped;
    start_sweep(10, 2);
    step();
    col_start_i = 7'd50; num_adc_i = 8'd8; start_i = 1'b1;
    step();
    start_i = 1'b0;
    for (int c = 3; c <= 5; c++) begin
      chk($sformatf("t4_done_c%0d", c), {31'b0, done_o}, {31'b0, c == 5});
      if (c < 5) step();
    end
    step();
    chk("t4_ignored_busy", {31'b0, busy_o}, 0);
    drain("t4");
    chk("t4_word_count", n_popped - base, 1);

    // T5: clear mid-sweep.
    word_ready_i = 1'b0;
    start_sweep(0, 20);
    for (int c = 0; c < 40; c++) step();
    chk("t5_pre_valid", {31'b0, word_valid_o}, 1);
    clear_i = 1'b1;
    exp_q.delete();
    step();
    clear_i = 1'b0;
    chk("t5_clr_busy", {31'b0, busy_o}, 0);
    chk("t5_clr_valid", {31'b0, word_valid_o}, 0);
    chk("t5_clr_word", word_o, 0);
    seen = 0;
    for (int c = 0; c < 40; c++) begin
      if (done_o || word_valid_o) seen++;
      step();
    end
    chk("t5_clr_quiet", seen, 0);

    // T6: reset mid-sweep.
    start_sweep(5, 20);
    for (int c = 0; c < 40; c++) step();
    rst_ni = 1'b0;
    #1;
    chk("t6_rst_busy", {31'b0, busy_o}, 0);
    chk("t6_rst_valid", {31'b0, word_valid_o}, 0);
    chk("t6_rst_wen", {31'b0, buf_w_en_o}, 0);
    exp_q.delete();
    step();
    rst_ni = 1'b1;
    seen = 0;
    for (int c = 0; c < 40; c++) begin
      if (done_o || word_valid_o || busy_o) seen++;
      step();
    end
    chk("t6_rst_quiet", seen, 0);

`ifdef OUTPUT_SEQ_SUM_EN
    // T7: sum 9+9+6 = 24.
    tbl[0] = 4'd9; tbl[1] = 4'd9; tbl[2] = 4'd6;
    word_ready_i = 1'b1;
    start_sweep(0, 3);
    wait_done(20, 1'b0, "t7_done");
    chk("t7_sum", {21'b0, sum_o}, 24);
    chk("t7_sum_valid", {31'b0, sum_valid_o}, 1);
    drain("t7");
    chk("t7_sum_valid_hold", {31'b0, sum_valid_o}, 1);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
